mest_pro_seg_decoder: RTL
=========================

MEST_PRO_SEG_DECODER -- requirements
Module: mest_pro_seg_decoder

Interface
REQ-001: Parameter SEG_WIDTH, default 7, SHALL be the width of the segment bus; bit 6 = segment a through bit 0 = segment g.
REQ-002: Parameter STABLE_COUNT, default 3, range 1-15, SHALL be the number of further consecutive matching samples needed before a pattern is decoded.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005: i_enable  input  1  SHALL be decoder enable; low holds the block idle.
REQ-006: i_segments  input  SEG_WIDTH  SHALL carry the segment pattern to be decoded, active-high segments.
REQ-007: o_value  output  4  SHALL carry the decoded hex digit.
REQ-008: o_blank  output  1  SHALL flag that the pattern was all-zero.
REQ-009: o_error  output  1  SHALL flag that the pattern is not in the decode table.
REQ-010: o_ambiguous  output  1  SHALL flag that the pattern maps to more than one digit.
REQ-011: o_valid  output  1  SHALL qualify o_value and the o_blank, o_error and o_ambiguous flags.
REQ-012: i_ready  input  1  SHALL be consumer acceptance of the current result.
REQ-013: o_overrun  output  1  SHALL be sticky; it is set when a decode result is dropped.

Function
REQ-014: Each edge SHALL register i_segments into sample register S; the stability counter SHALL clear when the new input differs from S, else increment, saturating at STABLE_COUNT.
REQ-015: A decode event SHALL occur on the edge at which the counter reaches STABLE_COUNT and S differs from the last-emitted pattern, or no pattern has been emitted since reset or enable-low.
REQ-016: Latency: pattern first sampled at edge E0 and held SHALL produce o_valid high after edge E0+STABLE_COUNT.
REQ-017: Decode table (pattern->value) SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 0011111->6, 1110000->7, 1111111->8, 1110011->9, 1110111->A, 0001101->C, 0111101->D, 1001111->E, 1000111->F.
REQ-018: 0011111 SHALL decode to 6 with o_ambiguous=1; all other table entries give o_ambiguous=0.
REQ-019: 0000000 SHALL give o_blank=1, o_value=0, o_error=0.
REQ-020: Any other pattern SHALL give o_error=1, o_value=0.
REQ-021: Every decode event SHALL update the last-emitted pattern, including blank and error events.
REQ-022: FSM states SHALL be IDLE (i_enable low), TRACK (no result pending) and HOLD (o_valid high).
REQ-023: FSM transitions SHALL be IDLE->TRACK when i_enable=1, TRACK->HOLD on a decode event, and HOLD->TRACK on an edge with i_ready=1 and no simultaneous event.
REQ-024: In HOLD, o_value and all flags SHALL remain stable until the accepting edge.
REQ-025: A decode event on the same edge as acceptance (o_valid & i_ready) SHALL load the new result and stay in HOLD, with no overrun.
REQ-026: A decode event in HOLD without i_ready SHALL be dropped, SHALL set o_overrun, and SHALL still update the last-emitted pattern.
REQ-027: A repeated identical stable pattern SHALL NOT re-emit; a pattern that changes and returns SHALL re-emit.
REQ-028: i_enable low at any edge SHALL force IDLE, clear o_valid (a pending result is discarded), the counter, the last-emitted record and o_overrun; S keeps sampling.
REQ-029: i_ready while o_valid=0 SHALL have no effect.

Reset
REQ-030: rst_n low SHALL immediately clear S, the counter, the last-emitted record and the FSM (IDLE), and drive o_value=0, o_blank=0, o_error=0, o_ambiguous=0, o_valid=0, o_overrun=0.
REQ-031: Reset asserted mid-HOLD SHALL discard the pending result; the first event after release SHALL decode normally.
REQ-032: Deassertion of rst_n SHALL be synchronized to clk by the integrator; no output SHALL change before the first edge after release.

Verification
REQ-033: Enable=1, ready=1, hold 1011011 from edge 0 -> o_valid=1, o_value=5 after edge 3; no re-emit while held.
REQ-034: Toggle input 1111110/0110000 every 2 cycles -> o_valid never asserts.
REQ-035: Ready=0; stable 1110111, then stable 1001111 -> o_value=A held, o_overrun=1; ready=1 pulse -> o_valid=0, no E emitted.
REQ-036: Patterns 0011111, 0000000, 1010101 in turn -> (6, ambiguous), (blank), (error), each with o_valid.
REQ-037: Result pending, drop i_enable one cycle -> o_valid=0 and o_overrun=0; unchanged input re-emits after STABLE_COUNT edges.
REQ-038: Assert rst_n=0 asynchronously mid-HOLD -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/mest_pro_seg_decoder_if.sv
// Bus bundle between a segment source/consumer and the seven-segment pattern decoder.
interface mest_pro_seg_decoder_if #(
    parameter int unsigned SEG_WIDTH = 7
);
    logic                 i_enable;
    logic [SEG_WIDTH-1:0] i_segments;
    logic                 i_ready;
    logic [3:0]           o_value;
    logic                 o_blank;
    logic                 o_error;
    logic                 o_ambiguous;
    logic                 o_valid;
    logic                 o_overrun;

    modport master (
        output i_enable, i_segments, i_ready,
        input  o_value, o_blank, o_error, o_ambiguous, o_valid, o_overrun
    );

    modport slave (
        input  i_enable, i_segments, i_ready,
        output o_value, o_blank, o_error, o_ambiguous, o_valid, o_overrun
    );
endinterface

// File: rtl/mest_pro_seg_decoder.sv
// Debounced seven-segment pattern decoder: a pattern stable for STABLE_COUNT further samples
// is decoded to a hex digit and held with a valid/ready handshake until accepted.
module mest_pro_seg_decoder #(
    parameter int unsigned SEG_WIDTH    = 7,
    parameter int unsigned STABLE_COUNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mest_pro_seg_decoder_if.slave bus
);

    if (STABLE_COUNT < 1 || STABLE_COUNT > 15) begin : g_bad_stable_count
        $error("STABLE_COUNT must be in 1..15");
    end

    localparam logic [3:0] STABLE = 4'(STABLE_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEG_WIDTH-1:0] seg_q;
    logic [3:0]           cnt_q, cnt_d;
    logic [SEG_WIDTH-1:0] last_q, last_d;
    logic                 last_vld_q, last_vld_d;
    logic [3:0]           value_q, value_d;
    logic                 blank_q, blank_d;
    logic                 error_q, error_d;
    logic                 amb_q, amb_d;
    logic                 overrun_q, overrun_d;
    logic                 decode_event;
    logic [6:0]           dec;

    // Result packing: {value[3:0], blank, error, ambiguous}
    function automatic logic [6:0] decode(input logic [SEG_WIDTH-1:0] p);
        logic [6:0] r;
        r = {4'h0, 1'b0, 1'b0, 1'b0};
        case (p)
            SEG_WIDTH'(7'b0000000): r = {4'h0, 1'b1, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1111110): r = {4'h0, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b0110000): r = {4'h1, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1101101): r = {4'h2, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1111001): r = {4'h3, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b0110011): r = {4'h4, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1011011): r = {4'h5, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b0011111): r = {4'h6, 1'b0, 1'b0, 1'b1};
            SEG_WIDTH'(7'b1110000): r = {4'h7, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1111111): r = {4'h8, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1110011): r = {4'h9, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1110111): r = {4'hA, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b0001101): r = {4'hC, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b0111101): r = {4'hD, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1001111): r = {4'hE, 1'b0, 1'b0, 1'b0};
            SEG_WIDTH'(7'b1000111): r = {4'hF, 1'b0, 1'b0, 1'b0};
            default:                r = {4'h0, 1'b0, 1'b1, 1'b0};
        endcase
        return r;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (!bus.i_enable || bus.i_segments != seg_q) begin
            cnt_d = '0;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 4'd1;
        end

        // Decoding S is safe here: the counter only advances when the new sample equals S
        decode_event = bus.i_enable && (cnt_d == STABLE) && (!last_vld_q || seg_q != last_q);
        dec          = decode(seg_q);
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        value_d    = value_q;
        blank_d    = blank_q;
        error_d    = error_q;
        amb_d      = amb_q;
        overrun_d  = overrun_q;

        if (!bus.i_enable) begin
            state_d    = IDLE;
            last_d     = '0;
            last_vld_d = 1'b0;
            value_d    = '0;
            blank_d    = 1'b0;
            error_d    = 1'b0;
            amb_d      = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            if (decode_event) begin
                last_d     = seg_q;
                last_vld_d = 1'b1;
            end
            case (state_q)
                IDLE, TRACK: begin
                    state_d = decode_event ? HOLD : TRACK;
                    if (decode_event) begin
                        {value_d, blank_d, error_d, amb_d} = dec;
                    end
                end
                HOLD: begin
                    // Acceptance and a new event on the same edge hand over without a gap
                    if (decode_event && bus.i_ready) begin
                        {value_d, blank_d, error_d, amb_d} = dec;
                    end else if (decode_event) begin
                        overrun_d = 1'b1;
                    end else if (bus.i_ready) begin
                        state_d = TRACK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seg_q      <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            value_q    <= '0;
            blank_q    <= 1'b0;
            error_q    <= 1'b0;
            amb_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= bus.i_segments;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            value_q    <= value_d;
            blank_q    <= blank_d;
            error_q    <= error_d;
            amb_q      <= amb_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.o_value     = value_q;
    assign bus.o_blank     = blank_q;
    assign bus.o_error     = error_q;
    assign bus.o_ambiguous = amb_q;
    assign bus.o_valid     = (state_q == HOLD);
    assign bus.o_overrun   = overrun_q;

endmodule
